bd_demod_rx: RTL and testbench

Receive demodulator stage. It slices 8-bit ADC samples from the RX front end into a binary line and recovers oversampled asynchronous bit frames. It assembles byte pairs into data_out_dem_0/data_out_dem_1 for the downstream decoder. It runs entirely on G_CLK_RX, which is the ADC sample clock.

---
 rtl/bd_demod_rx_if.sv | 22 ++
 rtl/bd_demod_rx.sv | 185 ++++++++++++++++++
 tb/tb_bd_demod_rx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bd_demod_rx_if.sv
// Receive-side bundle of bd_demod_rx: sample stream in, byte pair and status out.
interface bd_demod_rx_if;
    logic       en;
    logic [7:0] ADC;
    logic [7:0] data_out_dem_0;
    logic [7:0] data_out_dem_1;
    logic       pair_valid;
    logic       frame_err;
    logic       busy;

    // Source side: front end / test environment driving samples.
    modport master (
        output en, ADC,
        input  data_out_dem_0, data_out_dem_1, pair_valid, frame_err, busy
    );

    // Demodulator side.
    modport slave (
        input  en, ADC,
        output data_out_dem_0, data_out_dem_1, pair_valid, frame_err, busy
    );
endinterface

// File: rtl/bd_demod_rx.sv
// Receive demodulator: hysteresis slicer, oversampled async frame recovery
// with 3-sample majority vote, and byte-pair assembly for the decoder.
module bd_demod_rx #(
    parameter int         SPB          = 16,
    parameter logic [7:0] THR_HI       = 8'd160,
    parameter logic [7:0] THR_LO       = 8'd96,
    parameter int         PAIR_TIMEOUT = 4096
) (
    input  logic          G_CLK_RX,
    input  logic          reset,
    bd_demod_rx_if.slave  bus
);

    localparam int CW = $clog2(SPB);
    localparam int TW = $clog2(PAIR_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(SPB - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(SPB / 2 - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(SPB / 2);
    localparam logic [CW-1:0] CNT_V2   = CW'(SPB / 2 + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(PAIR_TIMEOUT);

    // Majority of three samples around mid-bit.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    logic          line_r;
    logic          line_d_r;
    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [2:0]    votes_r;
    logic [7:0]    shreg_r;
    logic          byte_sel_r;
    logic [TW-1:0] tmo_r;
    logic [7:0]    dem0_r;
    logic [7:0]    dem1_r;
    logic          pair_valid_r;
    logic          frame_err_r;

    logic          fall_s;
    logic          bit_end_s;
    logic          vote_s;

    assign fall_s    = line_d_r & ~line_r;
    assign bit_end_s = (cnt_r == CNT_LAST);
    assign vote_s    = maj3(votes_r);

    // Hysteresis slicer; between thresholds the line keeps its last value.
    always_ff @(posedge G_CLK_RX) begin
        if (reset) begin
            line_r   <= 1'b1;
            line_d_r <= 1'b1;
        end else begin
            if (bus.ADC >= THR_HI) begin
                line_r <= 1'b1;
            end else if (bus.ADC <= THR_LO) begin
                line_r <= 1'b0;
            end else begin
                line_r <= line_r;
            end
            line_d_r <= line_r;
        end
    end

    // Capture the three mid-bit samples used by the vote.
    always_ff @(posedge G_CLK_RX) begin
        if (reset) begin
            votes_r <= 3'b000;
        end else begin
            if (cnt_r == CNT_V0) votes_r[0] <= line_r;
            if (cnt_r == CNT_V1) votes_r[1] <= line_r;
            if (cnt_r == CNT_V2) votes_r[2] <= line_r;
        end
    end

    // Next-state decode; a falling edge only opens a frame from IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_s = ST_START;
                else        state_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) state_s = vote_s ? ST_IDLE : ST_DATA;
                else           state_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) state_s = ST_STOP;
                else                                  state_s = ST_DATA;
            end
            ST_STOP: begin
                if (bit_end_s) state_s = ST_IDLE;
                else           state_s = ST_STOP;
            end
            default: state_s = ST_IDLE;
        endcase
        if (!bus.en) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // Frame datapath, pair assembly, half-pair timeout and status pulses.
    always_ff @(posedge G_CLK_RX) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shreg_r      <= 8'h00;
            byte_sel_r   <= 1'b0;
            tmo_r        <= '0;
            dem0_r       <= 8'h00;
            dem1_r       <= 8'h00;
            pair_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else if (!bus.en) begin
            // Disabled: drop any frame or half-pair, keep delivered data.
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            byte_sel_r   <= 1'b0;
            tmo_r        <= '0;
            pair_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            pair_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;

            // IDLE parks the counter at 0 so START begins a fresh period.
            if (state_r == ST_IDLE || bit_end_s) cnt_r <= '0;
            else                                 cnt_r <= cnt_r + 1'b1;

            if (state_r == ST_START && bit_end_s) begin
                bit_idx_r <= 3'd0;
            end else if (state_r == ST_DATA && bit_end_s) begin
                shreg_r   <= {vote_s, shreg_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end

            if (state_r == ST_STOP && bit_end_s) begin
                if (!vote_s) begin
                    frame_err_r <= 1'b1;
                    byte_sel_r  <= 1'b0;
                end else if (byte_sel_r) begin
                    dem1_r       <= shreg_r;
                    pair_valid_r <= 1'b1;
                    byte_sel_r   <= 1'b0;
                end else begin
                    dem0_r     <= shreg_r;
                    byte_sel_r <= 1'b1;
                end
            end

            // Orphaned first byte is forgotten after a long idle gap.
            if (state_r == ST_IDLE && byte_sel_r && !fall_s) begin
                if (tmo_r == TMO_LAST) begin
                    byte_sel_r <= 1'b0;
                    tmo_r      <= '0;
                end else begin
                    tmo_r <= tmo_r + 1'b1;
                end
            end else begin
                tmo_r <= '0;
            end
        end
    end

    assign bus.data_out_dem_0 = dem0_r;
    assign bus.data_out_dem_1 = dem1_r;
    assign bus.pair_valid     = pair_valid_r;
    assign bus.frame_err      = frame_err_r;
    assign bus.busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_bd_demod_rx.sv
// Scoreboard bench for bd_demod_rx: frames are synthesised as ADC samples,
// expected pairs/errors (with their exact cycle) are queued at drive time.
module tb_bd_demod_rx;

    localparam int SPB = 16;
    localparam int PT  = 4096;
    // Start-bit first sample to STOP-evaluation edge: 2 cycles slicer/edge
    // detect plus ten bit periods.
    localparam int LAT = 2 + 10 * SPB;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        int         cyc;
    } pv_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    pv_t  pv_q[$];
    int   fe_q[$];

    bd_demod_rx_if bus ();

    bd_demod_rx #(.SPB(SPB), .PAIR_TIMEOUT(PT)) dut (
        .G_CLK_RX (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare every produced pulse against the queued expectations.
    always @(negedge clk) begin
        if (bus.pair_valid === 1'b1) begin
            if (pv_q.size() == 0) begin
                check("pv_unexpected", 32'd1, 32'd0);
            end else begin
                pv_t e;
                e = pv_q.pop_front();
                check("pv_d0", {24'd0, bus.data_out_dem_0}, {24'd0, e.d0});
                check("pv_d1", {24'd0, bus.data_out_dem_1}, {24'd0, e.d1});
                check("pv_cycle", cyc, e.cyc);
            end
        end
        if (bus.frame_err === 1'b1) begin
            if (fe_q.size() == 0) begin
                check("fe_unexpected", 32'd1, 32'd0);
            end else begin
                check("fe_cycle", cyc, fe_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.ADC = 8'd200;
        end
    endtask

    // mode 0 clean, 1 hysteresis dwell at 128, 2 mid-bit spike on '1' data bits.
    // kind 0 none, 1 expect frame_err, 2 expect pair (prev, b).
    // abort_bit >= 0 cuts the frame mid-bit with reset (abort_rst) or en=0.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int mode,
                              input int kind, input logic [7:0] prev,
                              input int abort_bit, input logic abort_rst);
        logic [9:0] bits;
        logic [7:0] lvl;
        int k;
        pv_t e;
        bits = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < SPB; s++) begin
                @(posedge clk); #1;
                if (i == 0 && s == 0) begin
                    k = cyc;
                    if (kind == 1) fe_q.push_back(k + LAT);
                    if (kind == 2) begin
                        e.d0 = prev; e.d1 = b; e.cyc = k + LAT;
                        pv_q.push_back(e);
                    end
                end
                if (i == abort_bit && s == SPB / 2) begin
                    bus.ADC = 8'd200;
                    if (abort_rst) reset = 1'b1;
                    else           bus.en = 1'b0;
                    @(posedge clk); #1;
                    reset  = 1'b0;
                    bus.en = 1'b1;
                    return;
                end
                lvl = bits[i] ? 8'd200 : 8'd50;
                if (mode == 1 && s >= 4) lvl = 8'd128;
                if (mode == 2 && bits[i] && i > 0 && i < 9 && s == 9) lvl = 8'd50;
                bus.ADC = lvl;
            end
        end
        idle(SPB);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int mode);
        send_frame(a, 1'b1, mode, 0, 8'h00, -1, 1'b0);
        send_frame(b, 1'b1, mode, 2, a, -1, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        check({tag, "_d0"}, {24'd0, bus.data_out_dem_0}, {24'd0, d0});
        check({tag, "_d1"}, {24'd0, bus.data_out_dem_1}, {24'd0, d1});
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset   = 1'b1;
        bus.en  = 1'b1;
        bus.ADC = 8'd200;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_d0", {24'd0, bus.data_out_dem_0}, 32'd0);
        check("rst_d1", {24'd0, bus.data_out_dem_1}, 32'd0);
        check("rst_pv", {31'd0, bus.pair_valid}, 32'd0);
        check("rst_fe", {31'd0, bus.frame_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2 * SPB);

        // Basic pair.
        send_pair(8'hA5, 8'h3C, 0);
        check_outs("t1", 8'hA5, 8'h3C);

        // False start: 5 low samples on an idle line.
        for (int s = 0; s < 40; s++) begin
            @(posedge clk); #1;
            bus.ADC = (s < 5) ? 8'd50 : 8'd200;
            if (s == 0) k = cyc;
            @(negedge clk);
            if (s == 1)  check("fs_busy_early", {31'd0, bus.busy}, 32'd0);
            if (s == 10) check("fs_busy_mid", {31'd0, bus.busy}, 32'd1);
            if (s == 25) check("fs_busy_end", {31'd0, bus.busy}, 32'd0);
        end
        check("fs_start_cycle", cyc - 39, k);
        check_outs("t2", 8'hA5, 8'h3C);

        // Bad stop bit, then a fresh pair.
        send_frame(8'h5A, 1'b0, 0, 1, 8'h00, -1, 1'b0);
        send_pair(8'h11, 8'h22, 0);
        check_outs("t3", 8'h11, 8'h22);

        // Hysteresis dwell on idle line, then dwell-shaped and spiked frames.
        repeat (40) begin
            @(posedge clk); #1;
            bus.ADC = 8'd128;
        end
        @(negedge clk);
        check("dwell_busy", {31'd0, bus.busy}, 32'd0);
        send_pair(8'hC3, 8'h96, 1);
        check_outs("t4h", 8'hC3, 8'h96);
        send_pair(8'hFF, 8'hB7, 2);
        check_outs("t4s", 8'hFF, 8'hB7);

        // Orphan first byte is dropped by the pair timeout.
        send_frame(8'h77, 1'b1, 0, 0, 8'h00, -1, 1'b0);
        idle(PT + 10);
        send_pair(8'h01, 8'h02, 0);
        check_outs("t5", 8'h01, 8'h02);

        // Reset in DATA bit 4 after a first byte.
        send_frame(8'h33, 1'b1, 0, 0, 8'h00, -1, 1'b0);
        send_frame(8'h44, 1'b1, 0, 0, 8'h00, 5, 1'b1);
        check_outs("t6r", 8'h00, 8'h00);
        check("t6r_pv", {31'd0, bus.pair_valid}, 32'd0);
        idle(2 * SPB);
        send_pair(8'h55, 8'h66, 0);
        check_outs("t6r_pair", 8'h55, 8'h66);

        // en dropped in DATA bit 4 after a first byte.
        send_frame(8'h12, 1'b1, 0, 0, 8'h00, -1, 1'b0);
        send_frame(8'h44, 1'b1, 0, 0, 8'h00, 5, 1'b0);
        check_outs("t6e", 8'h12, 8'h66);
        check("t6e_fe", {31'd0, bus.frame_err}, 32'd0);
        idle(2 * SPB);
        send_pair(8'h21, 8'h43, 0);
        check_outs("t6e_pair", 8'h21, 8'h43);

        idle(SPB);
        check("pv_pending", pv_q.size(), 32'd0);
        check("fe_pending", fe_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
